// File: rtl/tri_bus_pkg.sv
// tri_bus_pkg: shared FSM encoding and constants for the tristate bus drive controller.
package tri_bus_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, DRIVE, TURNAROUND} state_t;

    localparam logic [31:0] ENB_CLR = '0;

endpackage

// File: rtl/rr_arb.sv
// rr_arb: combinational round-robin arbiter, search starts at ptr and wraps.
module rr_arb #(
    parameter int NREQ = 4,
    parameter int PW   = NREQ > 1 ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant
);

    int idx;

    // Walk from the farthest candidate back to ptr so the nearest requester wins.
    always_comb begin
        grant = '0;
        idx = 0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = int'(ptr) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (req[idx]) grant = NREQ'(1) << idx;
        end
    end

endmodule

// File: rtl/tri_bus_drive_ctrl.sv
// tri_bus_drive_ctrl: round-robin owner of a shared tristate bus; data settles a cycle
// before the owner's enable, and the bus idles for TURN cycles between owners.
module tri_bus_drive_ctrl
    import tri_bus_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int W        = 8,
    parameter int MAXBURST = 8,
    parameter int TURN     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic [W-1:0]      drv_data,
    output logic [NREQ-1:0]   drv_enb,
    output logic              bus_busy
);

    localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(MAXBURST + 1);
    localparam int TW = TURN > 0 ? $clog2(TURN + 1) : 1;

    state_t          state, next_state;
    logic [PW-1:0]   ptr, owner, win;
    logic [NREQ-1:0] grant, own_hot;
    logic [CW-1:0]   cnt;
    logic [TW-1:0]   tcnt;
    logic            accept, done;

    rr_arb #(.NREQ(NREQ), .PW(PW)) u_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant)
    );

    always_comb begin
        win = '0;
        for (int i = 0; i < NREQ; i++) if (grant[i]) win = PW'(i);
    end

    assign own_hot = NREQ'(1) << owner;
    assign accept  = state == DRIVE && req_valid[owner];
    assign done    = accept && (req_last[owner] || cnt == CW'(MAXBURST - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:       next_state = |req_valid ? SETUP : IDLE;
            SETUP:      next_state = DRIVE;
            DRIVE:      next_state = done ? (TURN > 0 ? TURNAROUND : IDLE) : DRIVE;
            TURNAROUND: next_state = tcnt == TW'(TURN - 1) ? IDLE : TURNAROUND;
            default:    next_state = IDLE;
        endcase
    end

    always_comb begin
        bus_busy  = state != IDLE;
        req_ready = state == DRIVE ? req_valid & own_hot : '0;
    end

    // The winner's first beat is presented during SETUP but only counted once accepted in DRIVE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr      <= '0;
            owner    <= '0;
            cnt      <= '0;
            tcnt     <= '0;
            drv_data <= '0;
            drv_enb  <= ENB_CLR[NREQ-1:0];
        end else begin
            if (state == IDLE && |req_valid) begin
                owner    <= win;
                ptr      <= win == PW'(NREQ - 1) ? '0 : win + 1'b1;
                drv_data <= req_data[win*W +: W];
                cnt      <= '0;
            end
            if (accept) begin
                drv_data <= req_data[owner*W +: W];
                cnt      <= cnt + 1'b1;
            end
            tcnt    <= state == TURNAROUND ? tcnt + 1'b1 : '0;
            drv_enb <= next_state == DRIVE ? own_hot : ENB_CLR[NREQ-1:0];
        end
    end

endmodule
